// File: rtl/modulo_proximo_pc_pkg.sv
// Shared types for the next-address generator: FSM state encoding and the
// next-PC source select (also reused by the control unit for debug visibility).
package modulo_proximo_pc_pkg;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } estado_e;

  typedef enum logic [2:0] {
    SRC_INC  = 3'd0,
    SRC_IMM  = 3'd1,
    SRC_REG  = 3'd2,
    SRC_RAS  = 3'd3,
    SRC_ZERO = 3'd4,
    SRC_HOLD = 3'd5
  } src_sel_e;

endpackage

// File: rtl/modulo_proximo_pc_pilha_retorno.sv
// Return-address stack: register file, stack pointer and full/empty status.
// Push is dropped when full, pop is dropped when empty; clear only rewinds SP.
module modulo_proximo_pc_pilha_retorno
  import modulo_proximo_pc_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH  = 13,
  parameter int unsigned STACK_DEPTH = 8,
  parameter int unsigned SP_WIDTH    = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  push_i,
  input  logic                  pop_i,
  input  logic                  clear_i,
  input  logic [ADDR_WIDTH-1:0] push_data_i,
  output logic [ADDR_WIDTH-1:0] top_o,
  output logic                  empty_o,
  output logic                  full_o
);

  localparam int unsigned IdxW = $clog2(STACK_DEPTH);

  logic [SP_WIDTH-1:0]   sp_q, sp_d;
  logic [ADDR_WIDTH-1:0] mem_q [STACK_DEPTH];
  logic [ADDR_WIDTH-1:0] mem_d [STACK_DEPTH];
  logic [IdxW-1:0]       push_idx, top_idx;

  // SP is a power-of-two depth, so its low bits index the slot directly.
  assign push_idx = sp_q[IdxW-1:0];
  assign top_idx  = push_idx - IdxW'(1);
  assign top_o    = mem_q[top_idx];
  assign empty_o  = (sp_q == '0);
  assign full_o   = (sp_q == SP_WIDTH'(STACK_DEPTH));

  always_comb begin
    sp_d  = sp_q;
    mem_d = mem_q;
    if (clear_i) begin
      sp_d = '0;
    end else if (push_i && !full_o) begin
      mem_d[push_idx] = push_data_i;
      sp_d            = sp_q + SP_WIDTH'(1);
    end else if (pop_i && !empty_o) begin
      sp_d = sp_q - SP_WIDTH'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sp_q <= '0;
      for (int i = 0; i < int'(STACK_DEPTH); i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      sp_q  <= sp_d;
      mem_q <= mem_d;
    end
  end

endmodule

// File: rtl/modulo_proximo_pc.sv
// Next-address generator: priority mux over flow targets, RUN/HALT FSM and
// sticky overflow/underflow flags around the return-address stack.
module modulo_proximo_pc
  import modulo_proximo_pc_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH  = 13,
  parameter int unsigned STACK_DEPTH = 8,
  parameter int unsigned SP_WIDTH    = 4
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic [ADDR_WIDTH-1:0] Instrucao,
  input  logic [ADDR_WIDTH-1:0] Imediato,
  input  logic [ADDR_WIDTH-1:0] RegAlvo,
  input  logic                  BranchTaken,
  input  logic                  Jump,
  input  logic                  JumpReg,
  input  logic                  Call,
  input  logic                  Return,
  input  logic                  halt,
  input  logic                  loop_enable,
  output logic [ADDR_WIDTH-1:0] InstrucaoModificada,
  output logic                  StackEmpty,
  output logic                  StackFull,
  output logic                  Overflow,
  output logic                  Underflow,
  output logic                  Halted
);

  estado_e               estado_q, estado_d;
  src_sel_e              sel;
  logic                  ovf_q, ovf_d, unf_q, unf_d;
  logic                  push, pop, clear;
  logic [ADDR_WIDTH-1:0] pc_inc, ras_top;

  assign pc_inc = Instrucao + ADDR_WIDTH'(1);

  modulo_proximo_pc_pilha_retorno #(
    .ADDR_WIDTH  (ADDR_WIDTH),
    .STACK_DEPTH (STACK_DEPTH),
    .SP_WIDTH    (SP_WIDTH)
  ) u_pilha (
    .clk_i       (Clock),
    .rst_i       (Reset),
    .push_i      (push),
    .pop_i       (pop),
    .clear_i     (clear),
    .push_data_i (pc_inc),
    .top_o       (ras_top),
    .empty_o     (StackEmpty),
    .full_o      (StackFull)
  );

  always_comb begin
    sel      = SRC_INC;
    push     = 1'b0;
    pop      = 1'b0;
    clear    = 1'b0;
    ovf_d    = ovf_q;
    unf_d    = unf_q;
    estado_d = estado_q;
    if (Reset) begin
      sel = SRC_ZERO;
    end else begin
      unique case (estado_q)
        ST_RUN: begin
          if (halt) begin
            // Flow inputs are ignored while halt is raised.
            if (loop_enable) begin
              sel   = SRC_ZERO;
              clear = 1'b1;
              ovf_d = 1'b0;
              unf_d = 1'b0;
            end else begin
              sel      = SRC_HOLD;
              estado_d = ST_HALT;
            end
          end else if (Return) begin
            if (!StackEmpty) begin
              sel = SRC_RAS;
              pop = 1'b1;
            end else begin
              unf_d = 1'b1;
            end
          end else if (Call) begin
            sel = SRC_IMM;
            if (!StackFull) begin
              push = 1'b1;
            end else begin
              ovf_d = 1'b1;
            end
          end else if (JumpReg) begin
            sel = SRC_REG;
          end else if (Jump || BranchTaken) begin
            sel = SRC_IMM;
          end
        end
        ST_HALT: begin
          if (loop_enable) begin
            sel      = SRC_ZERO;
            clear    = 1'b1;
            ovf_d    = 1'b0;
            unf_d    = 1'b0;
            estado_d = ST_RUN;
          end else begin
            sel = SRC_HOLD;
          end
        end
        default: estado_d = ST_RUN;
      endcase
    end
  end

  always_comb begin
    unique case (sel)
      SRC_INC:  InstrucaoModificada = pc_inc;
      SRC_IMM:  InstrucaoModificada = Imediato;
      SRC_REG:  InstrucaoModificada = RegAlvo;
      SRC_RAS:  InstrucaoModificada = ras_top;
      SRC_HOLD: InstrucaoModificada = Instrucao;
      default:  InstrucaoModificada = '0;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      estado_q <= ST_RUN;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      estado_q <= estado_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
    end
  end

  assign Overflow  = ovf_q;
  assign Underflow = unf_q;
  assign Halted    = (estado_q == ST_HALT);

endmodule

// File: tb/tb_modulo_proximo_pc.sv
// Scenario bench for modulo_proximo_pc: per-cycle expected outputs are queued
// when stimulus is driven and compared when sampled on the falling edge.
module tb_modulo_proximo_pc;

  localparam logic [6:0] RET  = 7'h40;
  localparam logic [6:0] CALL = 7'h20;
  localparam logic [6:0] JR   = 7'h10;
  localparam logic [6:0] JMP  = 7'h08;
  localparam logic [6:0] BR   = 7'h04;
  localparam logic [6:0] HLT  = 7'h02;
  localparam logic [6:0] LOOP = 7'h01;

  typedef struct packed {
    logic        rst;
    logic [12:0] ins;
    logic [12:0] imm;
    logic [12:0] rg;
    logic [6:0]  ctl;
  } in_t;

  typedef struct packed {
    logic [12:0] out;
    logic        empty;
    logic        full;
    logic        ovf;
    logic        unf;
    logic        halted;
  } obs_t;

  logic        clk = 1'b0;
  logic        Reset, BranchTaken, Jump, JumpReg, Call, Return, halt, loop_enable;
  logic [12:0] Instrucao, Imediato, RegAlvo, InstrucaoModificada;
  logic        StackEmpty, StackFull, Overflow, Underflow, Halted;

  int   errors = 0;
  int   checks = 0;
  obs_t exp_q[$];

  always #5 clk = ~clk;

  modulo_proximo_pc #(
    .ADDR_WIDTH  (13),
    .STACK_DEPTH (8),
    .SP_WIDTH    (4)
  ) dut (
    .Clock               (clk),
    .Reset               (Reset),
    .Instrucao           (Instrucao),
    .Imediato            (Imediato),
    .RegAlvo             (RegAlvo),
    .BranchTaken         (BranchTaken),
    .Jump                (Jump),
    .JumpReg             (JumpReg),
    .Call                (Call),
    .Return              (Return),
    .halt                (halt),
    .loop_enable         (loop_enable),
    .InstrucaoModificada (InstrucaoModificada),
    .StackEmpty          (StackEmpty),
    .StackFull           (StackFull),
    .Overflow            (Overflow),
    .Underflow           (Underflow),
    .Halted              (Halted)
  );

  function automatic in_t mk(logic rst, logic [12:0] ins, logic [12:0] imm, logic [12:0] rg,
                             logic [6:0] ctl);
    in_t s;
    s.rst = rst; s.ins = ins; s.imm = imm; s.rg = rg; s.ctl = ctl;
    return s;
  endfunction

  function automatic obs_t ex(logic [12:0] o, logic e, logic f, logic ov, logic un, logic h);
    obs_t x;
    x.out = o; x.empty = e; x.full = f; x.ovf = ov; x.unf = un; x.halted = h;
    return x;
  endfunction

  function automatic obs_t sample();
    return ex(InstrucaoModificada, StackEmpty, StackFull, Overflow, Underflow, Halted);
  endfunction

  function automatic string fmt(obs_t x);
    return $sformatf("out=%0d empty=%b full=%b ovf=%b unf=%b halted=%b",
                     x.out, x.empty, x.full, x.ovf, x.unf, x.halted);
  endfunction

  task automatic drive(in_t s);
    Reset       = s.rst;
    Instrucao   = s.ins;
    Imediato    = s.imm;
    RegAlvo     = s.rg;
    Return      = s.ctl[6];
    Call        = s.ctl[5];
    JumpReg     = s.ctl[4];
    Jump        = s.ctl[3];
    BranchTaken = s.ctl[2];
    halt        = s.ctl[1];
    loop_enable = s.ctl[0];
  endtask

  task automatic test_reset();
    in_t  st[$];
    obs_t ev[$];
    obs_t got, want;
    st.push_back(mk(1, 13'h123, 13'd5, 13'd6, JMP | CALL)); ev.push_back(ex(0, 1, 0, 0, 0, 0));
    st.push_back(mk(1, 13'd40, 13'd5, 13'd6, RET));         ev.push_back(ex(0, 1, 0, 0, 0, 0));
    for (int i = 0; i < st.size(); i++) begin
      drive(st[i]);
      exp_q.push_back(ev[i]);
      @(negedge clk);
      got  = sample();
      want = exp_q.pop_front();
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL reset step %0d: got %s, expected %s", i, fmt(got), fmt(want));
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_sequential();
    in_t  st[$];
    obs_t ev[$];
    obs_t got, want;
    st.push_back(mk(0, 13'h1FFF, 13'd9, 13'd9, 0));   ev.push_back(ex(0, 1, 0, 0, 0, 0));
    st.push_back(mk(0, 13'h0AB, 13'd9, 13'd9, 0));    ev.push_back(ex(13'h0AC, 1, 0, 0, 0, 0));
    st.push_back(mk(0, 13'd5, 13'h155, 13'd9, BR));   ev.push_back(ex(13'h155, 1, 0, 0, 0, 0));
    st.push_back(mk(0, 13'd5, 13'd1, 13'h777, JR));   ev.push_back(ex(13'h777, 1, 0, 0, 0, 0));
    st.push_back(mk(0, 13'd5, 13'h40, 13'd9, JMP | BR)); ev.push_back(ex(13'h40, 1, 0, 0, 0, 0));
    st.push_back(mk(0, 13'd5, 13'd1, 13'd2, JR | JMP));  ev.push_back(ex(13'd2, 1, 0, 0, 0, 0));
    for (int i = 0; i < st.size(); i++) begin
      drive(st[i]);
      exp_q.push_back(ev[i]);
      @(negedge clk);
      got  = sample();
      want = exp_q.pop_front();
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL sequential step %0d: got %s, expected %s", i, fmt(got), fmt(want));
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_call_return();
    in_t  st[$];
    obs_t ev[$];
    obs_t got, want;
    st.push_back(mk(0, 13'd10, 13'd100, 13'd0, CALL)); ev.push_back(ex(13'd100, 1, 0, 0, 0, 0));
    st.push_back(mk(0, 13'd150, 13'd0, 13'd0, RET));   ev.push_back(ex(13'd11, 0, 0, 0, 0, 0));
    st.push_back(mk(0, 13'd0, 13'd0, 13'd0, 0));       ev.push_back(ex(13'd1, 1, 0, 0, 0, 0));
    for (int i = 0; i < st.size(); i++) begin
      drive(st[i]);
      exp_q.push_back(ev[i]);
      @(negedge clk);
      got  = sample();
      want = exp_q.pop_front();
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL call_return step %0d: got %s, expected %s", i, fmt(got), fmt(want));
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_back_to_back();
    in_t  st[$];
    obs_t ev[$];
    obs_t got, want;
    st.push_back(mk(0, 13'd1, 13'd10, 13'd0, CALL));  ev.push_back(ex(13'd10, 1, 0, 0, 0, 0));
    st.push_back(mk(0, 13'd10, 13'd20, 13'd0, CALL)); ev.push_back(ex(13'd20, 0, 0, 0, 0, 0));
    st.push_back(mk(0, 13'd20, 13'd0, 13'd0, RET));   ev.push_back(ex(13'd11, 0, 0, 0, 0, 0));
    st.push_back(mk(0, 13'd11, 13'd0, 13'd0, RET));   ev.push_back(ex(13'd2, 0, 0, 0, 0, 0));
    st.push_back(mk(0, 13'd2, 13'd0, 13'd0, 0));      ev.push_back(ex(13'd3, 1, 0, 0, 0, 0));
    for (int i = 0; i < st.size(); i++) begin
      drive(st[i]);
      exp_q.push_back(ev[i]);
      @(negedge clk);
      got  = sample();
      want = exp_q.pop_front();
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL back_to_back step %0d: got %s, expected %s", i, fmt(got), fmt(want));
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_overflow();
    in_t  st[$];
    obs_t ev[$];
    obs_t got, want;
    for (int i = 0; i < 8; i++) begin
      st.push_back(mk(0, 13'(i), 13'(200 + i), 13'd0, CALL));
      ev.push_back(ex(13'(200 + i), i == 0, 0, 0, 0, 0));
    end
    st.push_back(mk(0, 13'd9, 13'd50, 13'd0, CALL)); ev.push_back(ex(13'd50, 0, 1, 0, 0, 0));
    for (int k = 0; k < 8; k++) begin
      st.push_back(mk(0, 13'd300, 13'd0, 13'd0, RET));
      ev.push_back(ex(13'(8 - k), 0, k == 0, 1, 0, 0));
    end
    st.push_back(mk(0, 13'd0, 13'd0, 13'd0, 0));     ev.push_back(ex(13'd1, 1, 0, 1, 0, 0));
    for (int i = 0; i < st.size(); i++) begin
      drive(st[i]);
      exp_q.push_back(ev[i]);
      @(negedge clk);
      got  = sample();
      want = exp_q.pop_front();
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL overflow step %0d: got %s, expected %s", i, fmt(got), fmt(want));
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_underflow_priority();
    in_t  st[$];
    obs_t ev[$];
    obs_t got, want;
    st.push_back(mk(0, 13'd20, 13'd60, 13'd0, RET | CALL | JMP));
    ev.push_back(ex(13'd21, 1, 0, 1, 0, 0));
    st.push_back(mk(0, 13'd0, 13'd0, 13'd0, 0));    ev.push_back(ex(13'd1, 1, 0, 1, 1, 0));
    st.push_back(mk(0, 13'd40, 13'd0, 13'd0, RET)); ev.push_back(ex(13'd41, 1, 0, 1, 1, 0));
    for (int i = 0; i < st.size(); i++) begin
      drive(st[i]);
      exp_q.push_back(ev[i]);
      @(negedge clk);
      got  = sample();
      want = exp_q.pop_front();
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL underflow step %0d: got %s, expected %s", i, fmt(got), fmt(want));
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_halt();
    in_t  st[$];
    obs_t ev[$];
    obs_t got, want;
    st.push_back(mk(0, 13'd25, 13'd70, 13'd0, CALL)); ev.push_back(ex(13'd70, 1, 0, 1, 1, 0));
    st.push_back(mk(0, 13'd30, 13'd99, 13'd0, HLT));  ev.push_back(ex(13'd30, 0, 0, 1, 1, 0));
    st.push_back(mk(0, 13'd30, 13'd99, 13'd0, HLT | JMP)); ev.push_back(ex(13'd30, 0, 0, 1, 1, 1));
    st.push_back(mk(0, 13'd30, 13'd99, 13'd0, JMP));  ev.push_back(ex(13'd30, 0, 0, 1, 1, 1));
    st.push_back(mk(0, 13'd30, 13'd0, 13'd0, RET));   ev.push_back(ex(13'd30, 0, 0, 1, 1, 1));
    st.push_back(mk(0, 13'd30, 13'd99, 13'd0, LOOP)); ev.push_back(ex(13'd0, 0, 0, 1, 1, 1));
    st.push_back(mk(0, 13'd0, 13'd0, 13'd0, 0));      ev.push_back(ex(13'd1, 1, 0, 0, 0, 0));
    for (int i = 0; i < st.size(); i++) begin
      drive(st[i]);
      exp_q.push_back(ev[i]);
      @(negedge clk);
      got  = sample();
      want = exp_q.pop_front();
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL halt step %0d: got %s, expected %s", i, fmt(got), fmt(want));
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_loop_restart_run();
    in_t  st[$];
    obs_t ev[$];
    obs_t got, want;
    st.push_back(mk(0, 13'd5, 13'd9, 13'd0, CALL));  ev.push_back(ex(13'd9, 1, 0, 0, 0, 0));
    st.push_back(mk(0, 13'd9, 13'd3, 13'd0, HLT | LOOP | JMP));
    ev.push_back(ex(13'd0, 0, 0, 0, 0, 0));
    st.push_back(mk(0, 13'd0, 13'd0, 13'd0, 0));     ev.push_back(ex(13'd1, 1, 0, 0, 0, 0));
    for (int i = 0; i < st.size(); i++) begin
      drive(st[i]);
      exp_q.push_back(ev[i]);
      @(negedge clk);
      got  = sample();
      want = exp_q.pop_front();
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL loop_restart step %0d: got %s, expected %s", i, fmt(got), fmt(want));
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset_mid();
    in_t  st[$];
    obs_t ev[$];
    obs_t got, want;
    for (int i = 0; i < 8; i++) begin
      st.push_back(mk(0, 13'(i), 13'(400 + i), 13'd0, CALL));
      ev.push_back(ex(13'(400 + i), i == 0, 0, 0, 0, 0));
    end
    st.push_back(mk(0, 13'd8, 13'd50, 13'd0, CALL)); ev.push_back(ex(13'd50, 0, 1, 0, 0, 0));
    for (int k = 0; k < 5; k++) begin
      st.push_back(mk(0, 13'd300, 13'd0, 13'd0, RET));
      ev.push_back(ex(13'(8 - k), 0, k == 0, 1, 0, 0));
    end
    st.push_back(mk(1, 13'd77, 13'd5, 13'd6, RET | JMP)); ev.push_back(ex(13'd0, 0, 0, 1, 0, 0));
    st.push_back(mk(0, 13'd0, 13'd0, 13'd0, 0));   ev.push_back(ex(13'd1, 1, 0, 0, 0, 0));
    st.push_back(mk(0, 13'd10, 13'd0, 13'd0, RET)); ev.push_back(ex(13'd11, 1, 0, 0, 0, 0));
    for (int i = 0; i < st.size(); i++) begin
      drive(st[i]);
      exp_q.push_back(ev[i]);
      @(negedge clk);
      got  = sample();
      want = exp_q.pop_front();
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL reset_mid step %0d: got %s, expected %s", i, fmt(got), fmt(want));
      end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    drive(mk(1, 13'd0, 13'd0, 13'd0, 0));
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_sequential();
    test_call_return();
    test_back_to_back();
    test_overflow();
    test_underflow_priority();
    test_halt();
    test_loop_restart_run();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/modulo_proximo_pc.md
Name: modulo_proximo_pc

Overview:
- Next-address generator feeding the program counter's modified-address input.
- Takes the current instruction address plus control-unit flow signals and selects the next address: sequential, branch, jump, register jump, call or return.
- Holds a return-address stack (RAS) for call/return.
- Tracks run/halt state so its stack stays coherent with PC halt and loop-restart behaviour.

Parameters:
- ADDR_WIDTH, 13, instruction address width; must match the PC.
- STACK_DEPTH, 8, number of RAS entries (power of two, ≥2).
- SP_WIDTH, 4, stack-pointer width; must satisfy 2^SP_WIDTH > STACK_DEPTH.

Ports:
- Clock  in  1  system clock, rising edge
- Reset  in  1  synchronous, active-high reset
- Instrucao  in  ADDR_WIDTH  current PC value
- Imediato  in  ADDR_WIDTH  absolute target for branch, jump and call
- RegAlvo  in  ADDR_WIDTH  register-supplied target for JumpReg
- BranchTaken  in  1  conditional branch resolved taken
- Jump  in  1  unconditional jump
- JumpReg  in  1  jump to RegAlvo
- Call  in  1  jump to Imediato and push return address
- Return  in  1  pop return address and jump to it
- halt  in  1  HALT instruction active
- loop_enable  in  1  restart program after halt
- InstrucaoModificada  out  ADDR_WIDTH  next PC value (combinational)
- StackEmpty  out  1  SP == 0
- StackFull  out  1  SP == STACK_DEPTH
- Overflow  out  1  sticky: call attempted while full
- Underflow  out  1  sticky: return attempted while empty
- Halted  out  1  FSM in HALT state

Behaviour:
- Reset values: SP=0, all stack entries 0, Overflow=0, Underflow=0, state RUN, InstrucaoModificada=0.
- During Reset, InstrucaoModificada=0 regardless of other inputs.
- PC_INC = Instrucao+1, modulo 2^ADDR_WIDTH; all-ones wraps to 0 with no flag.
- InstrucaoModificada is combinational in the same cycle. The PC samples it at the rising edge, so there is zero added latency.
- Target priority in RUN, highest first: Return, Call, JumpReg, Jump, BranchTaken, PC_INC.
- Simultaneous Call and Return: Return wins; no push occurs.
- Return with SP>0: output stack[SP-1]; SP decrements at the edge.
- Return with SP==0: output PC_INC; SP unchanged; Underflow set at the edge.
- Call with SP<STACK_DEPTH: output Imediato; stack[SP] ← PC_INC and SP increments at the edge.
- Call with SP==STACK_DEPTH: output Imediato; push discarded; Overflow set at the edge.
- JumpReg outputs RegAlvo; Jump and BranchTaken output Imediato. None of these touch the stack.
- FSM states are RUN and HALT.
  - RUN → HALT when halt=1 and loop_enable=0.
  - RUN with halt=1 and loop_enable=1: output 0; SP, Overflow and Underflow clear at the edge; stay in RUN.
  - While halt=1, all flow inputs are ignored.
  - HALT: output Instrucao (hold); stack frozen.
  - HALT → RUN when loop_enable=1: output 0 that cycle; SP and flags clear.
  - HALT exit otherwise requires Reset; dropping halt alone does not leave HALT.
- Overflow and Underflow clear only on Reset or loop restart.
- Halted=1 exactly in the HALT state.

Decomposition:
- Shared package holds the FSM state encoding (ST_RUN, ST_HALT) and a next-PC source-select enumeration (SRC_INC, SRC_IMM, SRC_REG, SRC_RAS, SRC_ZERO, SRC_HOLD). The control unit reuses the select enumeration for debug.
- Sub-module pilha_retorno: the RAS register file, SP counter and full/empty logic, with push/pop/clear inputs and a top output.
- Top level contains the priority mux and the FSM.

Test Plan:
- Sequential wrap: Reset, then Instrucao=13'h1FFF, no flow signals → InstrucaoModificada=0; flags 0.
- Call/return: Instrucao=10, Call, Imediato=100 → output 100, SP=1. Next cycle Instrucao=150, Return → output 11, SP=0, StackEmpty=1.
- Overflow: 8 calls from addresses 0..7 → StackFull=1. A 9th call with Imediato=50 → output 50, Overflow=1, SP=8. The next 8 returns yield 8,7,…,1.
- Underflow and priority: empty stack, Instrucao=20, Return+Call+Jump, Imediato=60 → output 21, Underflow=1, SP=0.
- Halt hold: halt=1, loop_enable=0 at Instrucao=30 → Halted=1 next cycle. Output stays 30 with Jump asserted. Raising loop_enable → output 0, then Halted=0 and SP=0.
- Reset mid-operation: SP=3, Overflow=1, assert Reset for one cycle → output 0 during Reset; after Reset SP=0, StackEmpty=1, Overflow=0, Halted=0.
